corr_stream: RTL and testbench

- Parametrised streaming sliding-window correlator; next generation of the fixed 8-bit/16-bit correlator.
- Computes y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k] on a valid-qualified input stream.
- Coefficients are run-time loadable, and warm-up is suppressed.
- Registered threshold-hit flag for downstream detection logic.
- Sits between the sample source and the peak/detect stage; 2-stage pipeline, no backpressure.

---
 rtl/corr_stream.sv | 116 +++++++++++
 tb/tb_corr_stream.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/corr_stream.sv
// rtl/corr_stream.sv - parametrised streaming sliding-window correlator with threshold hit
// Window/fill stage, registered products, registered adder-tree sum; 2-cycle latency, no backpressure.
module corr_stream #(
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int TAPS = 4,
    parameter int AW   = $clog2(TAPS),
    parameter int OW   = DW + CW + $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_wdata,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [OW-1:0] thresh,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    output logic          hit
);
    localparam int PW = DW + CW;
    localparam int NW = $clog2(TAPS + 1);

    logic [DW-1:0] x_q    [TAPS];
    logic [DW-1:0] x_d    [TAPS];
    logic [CW-1:0] c_q    [TAPS];
    logic [CW-1:0] c_d    [TAPS];
    logic [PW-1:0] prod_q [TAPS];
    logic [PW-1:0] prod_d [TAPS];
    logic [NW-1:0] fill_q, fill_d;
    logic          acc_q, acc_d;
    logic          v1_q, v1_d;
    logic          out_valid_q, out_valid_d;
    logic          hit_q, hit_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic [OW-1:0] sum;

    // Window, fill count and coefficient bank; acc_d flags an accepted sample that completes the window.
    always_comb begin
        x_d    = x_q;
        c_d    = c_q;
        fill_d = fill_q;
        acc_d  = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            if (coef_we && (coef_addr == AW'(k))) begin
                c_d[k] = coef_wdata;
            end
        end
        if (clear) begin
            for (int k = 0; k < TAPS; k++) begin
                x_d[k] = '0;
            end
            fill_d = '0;
        end else if (in_valid) begin
            x_d[0] = in_data;
            for (int k = 1; k < TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
            if (fill_q != NW'(TAPS)) begin
                fill_d = fill_q + NW'(1);
            end
            acc_d = (fill_q >= NW'(TAPS - 1));
        end
    end

    // Products use the coefficient bank as it stands after the acceptance edge.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = PW'(x_q[k]) * PW'(c_q[k]);
        end
        v1_d = acc_q && !clear;
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + OW'(prod_q[k]);
        end
        out_valid_d = v1_q && !clear;
        out_data_d  = out_valid_d ? sum : out_data_q;
        hit_d       = out_valid_d && (sum >= thresh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k]    <= '0;
                c_q[k]    <= CW'(1);
                prod_q[k] <= '0;
            end
            fill_q      <= '0;
            acc_q       <= 1'b0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            hit_q       <= 1'b0;
        end else begin
            x_q         <= x_d;
            c_q         <= c_d;
            prod_q      <= prod_d;
            fill_q      <= fill_d;
            acc_q       <= acc_d;
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            hit_q       <= hit_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign hit       = hit_q;

endmodule

// File: tb/tb_corr_stream.sv
// tb/tb_corr_stream.sv - self-checking bench for corr_stream against a queue-based reference model
module tb_corr_stream;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int TAPS = 4;
    localparam int AW   = 2;
    localparam int OW   = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [CW-1:0] coef_wdata = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [OW-1:0] thresh = '1;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          hit;

    corr_stream #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .thresh     (thresh),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .hit        (hit)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int unsigned   coefm [TAPS];
    logic [DW-1:0] hist [$];
    logic [OW-1:0] sched [int];
    logic [OW-1:0] last_d = '0;
    logic [OW-1:0] obs_d [$];
    logic          obs_h [$];

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) coefm[k] = 1;
        hist.delete();
        sched.delete();
        last_d = '0;
    endtask

    // Coefficient write lands before the same-edge sample's products are formed.
    task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit we,
                              input logic [AW-1:0] a, input logic [CW-1:0] w, input bit clr);
        int unsigned y;
        if (we) coefm[a] = int'(w);
        if (clr) begin
            hist.delete();
            if (sched.exists(cyc)) sched.delete(cyc);
            if (sched.exists(cyc + 1)) sched.delete(cyc + 1);
        end else if (v) begin
            hist.push_front(d);
            if (hist.size() > TAPS) void'(hist.pop_back());
            if (hist.size() == TAPS) begin
                y = 0;
                for (int k = 0; k < TAPS; k++) y += coefm[k] * 32'(hist[k]);
                sched[cyc + 2] = OW'(y);
            end
        end
    endtask

    task automatic check_outputs();
        logic          ev;
        logic [OW-1:0] ed;
        logic          eh;
        if (sched.exists(cyc)) begin
            ev = 1'b1;
            ed = sched[cyc];
            eh = (ed >= thresh);
            last_d = ed;
        end else begin
            ev = 1'b0;
            ed = last_d;
            eh = 1'b0;
        end
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_data", 64'(out_data), 64'(ed));
        chk("hit", 64'(hit), 64'(eh));
        if (out_valid === 1'b1) begin
            obs_d.push_back(out_data);
            obs_h.push_back(hit);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit we,
                        input logic [AW-1:0] a, input logic [CW-1:0] w, input bit clr);
        in_valid = v; in_data = d; coef_we = we; coef_addr = a; coef_wdata = w; clear = clr;
        @(posedge clk);
        cyc++;
        model_edge(v, d, we, a, w, clr);
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0; clear = 1'b0;
        check_outputs();
    endtask

    task automatic feed(input int d);
        step(1'b1, DW'(d), 1'b0, '0, '0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        obs_d.delete();
        obs_h.delete();
    endtask

    task automatic wcoef(input int a, input int w);
        step(1'b0, '0, 1'b1, AW'(a), CW'(w), 1'b0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_hit", 64'(hit), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        obs_d.delete();
        obs_h.delete();
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_hit", 64'(hit), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default coefficients: moving sum
        for (int i = 1; i <= 5; i++) feed(i);
        idle(3);
        chk("t1_count", 64'(obs_d.size()), 64'd2);
        chk("t1_y0", 64'(obs_d[0]), 64'd10);
        chk("t1_y1", 64'(obs_d[1]), 64'd14);

        // Loaded coefficients, then a same-edge write to c0
        for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
        do_clear();
        for (int i = 1; i <= 5; i++) feed(i);
        idle(3);
        chk("t2_count", 64'(obs_d.size()), 64'd2);
        chk("t2_y0", 64'(obs_d[0]), 64'd20);
        chk("t2_y1", 64'(obs_d[1]), 64'd30);
        do_clear();
        for (int i = 1; i <= 4; i++) feed(i);
        step(1'b1, DW'(5), 1'b1, AW'(0), CW'(0), 1'b0);
        idle(3);
        chk("t2w_count", 64'(obs_d.size()), 64'd2);
        chk("t2w_y1", 64'(obs_d[1]), 64'd25);
        for (int k = 0; k < TAPS; k++) wcoef(k, 1);

        // Gapped stream
        do_clear();
        feed(1); idle(1); feed(2); idle(2); feed(3); feed(4);
        idle(3);
        chk("t3_count", 64'(obs_d.size()), 64'd1);
        chk("t3_y0", 64'(obs_d[0]), 64'd10);

        // Clear with a result in flight, then refill
        do_clear();
        for (int i = 1; i <= 4; i++) feed(i);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        feed(9); feed(9); feed(9);
        idle(3);
        chk("t4_none", 64'(obs_d.size()), 64'd0);
        feed(9);
        idle(3);
        chk("t4_count", 64'(obs_d.size()), 64'd1);
        chk("t4_y0", 64'(obs_d[0]), 64'd36);

        // Threshold
        thresh = OW'(15);
        do_clear();
        for (int i = 1; i <= 6; i++) feed(i);
        idle(3);
        chk("t5_count", 64'(obs_d.size()), 64'd3);
        chk("t5_y2", 64'(obs_d[2]), 64'd18);
        chk("t5_h0", 64'(obs_h[0]), 64'd0);
        chk("t5_h1", 64'(obs_h[1]), 64'd0);
        chk("t5_h2", 64'(obs_h[2]), 64'd1);

        // Asynchronous reset mid-stream restores unit coefficients
        wcoef(2, 7);
        do_clear();
        for (int i = 1; i <= 5; i++) feed(i * 10);
        async_reset();
        for (int i = 0; i < 4; i++) feed(255);
        idle(3);
        chk("t6_count", 64'(obs_d.size()), 64'd1);
        chk("t6_y0", 64'(obs_d[0]), 64'd1020);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) thresh = OW'($urandom_range(0, 150000));
            step(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 7) == 0),
                 AW'($urandom), CW'($urandom), ($urandom_range(0, 39) == 0));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
